// File: rtl/instr_mem_loadable_pkg.sv
// Shared definitions for the loadable instruction memory.
// - FSM state encoding (CLEAR, IDLE, LOAD) as legacy-compatible localparams.
// - NOP opcode, also used by the decoder and the assembler.
// - Default address and data widths for the fetch path.
package instr_mem_loadable_pkg;

    // Default geometry of the instruction store.
    localparam int unsigned DefDataW = 8;
    localparam int unsigned DefAddrW = 8;

    // NOP opcode: the clear sequence writes it, and instr holds it out of reset.
    localparam logic [7:0] NopWord = 8'hF0;

    // FSM state encoding.
    localparam logic [1:0] StClear = 2'd0;
    localparam logic [1:0] StIdle  = 2'd1;
    localparam logic [1:0] StLoad  = 2'd2;

endpackage

// File: rtl/imem_sp_ram.sv
// Single-port synchronous RAM with a registered read and a write enable.
// Ports:
//   clk     - clock, rising edge
//   reset   - synchronous active-high; resets only the read register
//   addr    - shared read/write address
//   we      - write enable; wdata is stored at addr on the rising edge
//   wdata   - write data
//   re      - read enable; rdata loads mem[addr] on the rising edge
//   rdata   - registered read data; holds its value while re is low
module imem_sp_ram #(
    parameter int unsigned       DATA_W    = 8,
    parameter int unsigned       ADDR_W    = 8,
    parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] addr,
    input  logic              we,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    output logic [DATA_W-1:0] rdata
);

    localparam int unsigned Depth = 2 ** ADDR_W;

    // The storage array is not reset; its contents are defined by the clear sequence.
    logic [DATA_W-1:0] mem_q [Depth];
    logic [DATA_W-1:0] rdata_q;
    logic [DATA_W-1:0] rdata_d;

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= wdata;
        end
    end

    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = mem_q[addr];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rdata_q <= RESET_VAL;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/instr_mem_loadable.sv
// Loadable instruction memory for the MCU fetch path.
// After reset it fills every word with NOP (CLEAR). It then serves 1-cycle-latency fetches
// (IDLE), or accepts a byte-stream burst that is written from address 0 upwards (LOAD).
// Ports:
//   clk, reset          - clock and synchronous active-high reset
//   fetch_req/addr      - fetch request from the PC stage; dropped while busy
//   instr, instr_valid  - registered fetch result; instr holds when no fetch is served
//   busy                - high in CLEAR or LOAD
//   load_start/len      - start a burst of min(len, depth) words (honoured only in IDLE)
//   load_data/valid     - load word stream
//   load_ready          - loader accepts a word this cycle
//   load_done           - one-cycle pulse when a burst completes
//   load_count          - words written in the current or most recent burst
module instr_mem_loadable
    import instr_mem_loadable_pkg::*;
#(
    parameter int unsigned       DATA_W   = DefDataW,
    parameter int unsigned       ADDR_W   = DefAddrW,
    parameter logic [DATA_W-1:0] NOP_WORD = NopWord
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic [DATA_W-1:0] instr,
    output logic              instr_valid,
    output logic              busy,
    input  logic              load_start,
    input  logic [ADDR_W:0]   load_len,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_valid,
    output logic              load_ready,
    output logic              load_done,
    output logic [ADDR_W:0]   load_count
);

    localparam logic [ADDR_W:0]   DepthLen = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W-1:0] PtrOne   = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   CntOne   = {{ADDR_W{1'b0}}, 1'b1};

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;
    logic [ADDR_W-1:0] wptr_q, wptr_d;
    logic [ADDR_W:0]   load_count_q, load_count_d;
    logic [ADDR_W:0]   target_q, target_d;
    logic              instr_valid_q, instr_valid_d;
    logic              load_done_q, load_done_d;

    logic [ADDR_W-1:0] ram_addr;
    logic              ram_we;
    logic [DATA_W-1:0] ram_wdata;
    logic              ram_re;
    logic [ADDR_W:0]   len_clamped;
    logic [ADDR_W:0]   count_inc;

    assign len_clamped = (load_len > DepthLen) ? DepthLen : load_len;
    assign count_inc   = load_count_q + CntOne;

    always_comb begin
        state_d       = state_q;
        clr_ptr_d     = clr_ptr_q;
        wptr_d        = wptr_q;
        load_count_d  = load_count_q;
        target_d      = target_q;
        instr_valid_d = 1'b0;
        load_done_d   = 1'b0;
        ram_addr      = fetch_addr;
        ram_we        = 1'b0;
        ram_wdata     = load_data;
        ram_re        = 1'b0;

        case (state_q)
            StClear: begin
                ram_addr  = clr_ptr_q;
                ram_we    = 1'b1;
                ram_wdata = NOP_WORD;
                clr_ptr_d = clr_ptr_q + PtrOne;
                if (clr_ptr_q == {ADDR_W{1'b1}}) begin
                    state_d = StIdle;
                end
            end

            StIdle: begin
                // A fetch in the load_start cycle is still served: no write happens this cycle.
                ram_addr      = fetch_addr;
                ram_re        = fetch_req;
                instr_valid_d = fetch_req;
                if (load_start) begin
                    target_d     = len_clamped;
                    load_count_d = '0;
                    wptr_d       = '0;
                    if (len_clamped == '0) begin
                        load_done_d = 1'b1;
                    end else begin
                        state_d = StLoad;
                    end
                end
            end

            StLoad: begin
                ram_addr  = wptr_q;
                ram_wdata = load_data;
                if (load_valid) begin
                    ram_we       = 1'b1;
                    wptr_d       = wptr_q + PtrOne;
                    load_count_d = count_inc;
                    if (count_inc == target_q) begin
                        state_d     = StIdle;
                        load_done_d = 1'b1;
                    end
                end
            end

            default: begin
                state_d   = StClear;
                clr_ptr_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= StClear;
            clr_ptr_q     <= '0;
            wptr_q        <= '0;
            load_count_q  <= '0;
            target_q      <= '0;
            instr_valid_q <= 1'b0;
            load_done_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            clr_ptr_q     <= clr_ptr_d;
            wptr_q        <= wptr_d;
            load_count_q  <= load_count_d;
            target_q      <= target_d;
            instr_valid_q <= instr_valid_d;
            load_done_q   <= load_done_d;
        end
    end

    // The RAM read register doubles as the instr output register.
    imem_sp_ram #(
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .RESET_VAL (NOP_WORD)
    ) u_ram (
        .clk   (clk),
        .reset (reset),
        .addr  (ram_addr),
        .we    (ram_we),
        .wdata (ram_wdata),
        .re    (ram_re),
        .rdata (instr)
    );

    assign instr_valid = instr_valid_q;
    assign busy        = (state_q != StIdle);
    // The state leaves LOAD on the last accepted word, so LOAD alone implies room left.
    assign load_ready  = (state_q == StLoad);
    assign load_done   = load_done_q;
    assign load_count  = load_count_q;

endmodule
